// File: rtl/retire_stage_pkg.sv
// retire_stage_pkg: shared types and widths for the ROB retire interface.
package retire_stage_pkg;
    localparam int RT_WAYS   = 3;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 64;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
        logic [XLEN-1:0]      NPC;
        logic                 halt;
    } ROB_RT_PACKET;

    typedef struct packed {
        logic                 wr_en;
        logic [REG_IDX_W-1:0] wr_idx;
        logic [XLEN-1:0]      wr_data;
    } RT_REG_PACKET;

    typedef enum logic [1:0] {RT_RUN, RT_SQUASH, RT_HALTED} RETIRE_STATE;
endpackage

// File: rtl/retire_stage_select.sv
// retire_select: in-order accept mask, stopping after the first invalid way,
// taken branch or halt; the oldest stopping way is reported.
module retire_select #(
    parameter int NUM_WAYS = 3,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                run,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] take_branch,
    input  logic [NUM_WAYS-1:0] halt,
    output logic [NUM_WAYS-1:0] accepted,
    output logic [WAY_W-1:0]    stop_way,
    output logic                stop_is_branch,
    output logic                stop_is_halt
);
    logic live;

    always_comb begin
        accepted       = '0;
        stop_way       = '0;
        stop_is_branch = 1'b0;
        stop_is_halt   = 1'b0;
        live           = run;
        for (int i = 0; i < NUM_WAYS; i++) begin
            accepted[i] = live && valid[i];
            // halt outranks a taken branch on the same packet
            if (accepted[i] && (halt[i] || take_branch[i])) begin
                stop_way       = WAY_W'(i);
                stop_is_halt   = halt[i];
                stop_is_branch = !halt[i];
            end
            live = accepted[i] && !halt[i] && !take_branch[i];
        end
    end
endmodule

// File: rtl/retire_stage.sv
// retire_stage: commits up to NUM_WAYS ROB packets per cycle to the regfile,
// raising a one-cycle squash on taken branches and freezing on halt.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int NUM_WAYS = RT_WAYS,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  ROB_RT_PACKET       RT_packet_in  [NUM_WAYS],
    output RT_REG_PACKET       RF_packet_out [NUM_WAYS],
    output logic               squash_flag,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               halted,
    output logic [1:0]         retire_num,
    output logic [CNT_W-1:0]   retired_count
);
    RETIRE_STATE         state;
    logic [NUM_WAYS-1:0] valid, take_branch, halt, accepted;
    logic [WAY_W-1:0]    stop_way;
    logic                stop_is_branch, stop_is_halt;
    logic [1:0]          n_acc;

    always_comb begin
        valid       = '0;
        take_branch = '0;
        halt        = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            valid[i]       = RT_packet_in[i].valid;
            take_branch[i] = RT_packet_in[i].take_branch;
            halt[i]        = RT_packet_in[i].halt;
        end
    end

    assign n_acc = 2'($countones(accepted));

    retire_select #(.NUM_WAYS(NUM_WAYS)) u_select (
        .run           (state == RT_RUN),
        .valid         (valid),
        .take_branch   (take_branch),
        .halt          (halt),
        .accepted      (accepted),
        .stop_way      (stop_way),
        .stop_is_branch(stop_is_branch),
        .stop_is_halt  (stop_is_halt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WAYS; i++) RF_packet_out[i] <= '0;
            state         <= RT_RUN;
            squash_flag   <= 1'b0;
            redirect_pc   <= '0;
            halted        <= 1'b0;
            retire_num    <= '0;
            retired_count <= '0;
        end else begin
            // r0 is hardwired zero, so its write enable is suppressed
            for (int i = 0; i < NUM_WAYS; i++)
                RF_packet_out[i] <= '{wr_en:   accepted[i] && (RT_packet_in[i].dest_reg_idx != '0),
                                      wr_idx:  RT_packet_in[i].dest_reg_idx,
                                      wr_data: RT_packet_in[i].value};
            squash_flag   <= stop_is_branch;
            redirect_pc   <= stop_is_branch ? RT_packet_in[stop_way].NPC : '0;
            halted        <= halted || stop_is_halt;
            retire_num    <= n_acc;
            retired_count <= retired_count + CNT_W'(n_acc);
            state         <= stop_is_halt          ? RT_HALTED :
                             stop_is_branch        ? RT_SQUASH :
                             (state == RT_SQUASH)  ? RT_RUN    : state;
        end
    end
endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Consumer end of the ROB retire interface.
- Each cycle it takes up to 3 in-order retire packets from the ROB head and commits them to the architectural register file through registered write ports.
- Detects taken branches and raises a one-cycle squash with a redirect PC; detects halt and freezes the machine.
- Keeps a retired-instruction counter. Sits between the ROB and the architectural regfile/fetch redirect.

Parameters:
- NUM_WAYS, 3, retire width; equals ROB retire packet count.
- XLEN, 32, data/PC width.
- REG_IDX_W, 5, architectural register index width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- RT_packet_in  in  NUM_WAYS x ROB_RT_PACKET  fields: valid, dest_reg_idx, value, take_branch, NPC, halt. Way 0 is the oldest.
- RF_packet_out  out  NUM_WAYS x RT_REG_PACKET  fields: wr_en, wr_idx[REG_IDX_W], wr_data[XLEN]; registered.
- squash_flag  out  1  one-cycle pulse; clears ROB/RS/MT and redirects fetch.
- redirect_pc  out  XLEN  branch target; meaningful only while squash_flag=1.
- halted  out  1  sticky halt indication.
- retire_num  out  2  number of packets committed in the previous cycle (0..3).
- retired_count  out  CNT_W  running total of committed packets.

Behaviour:
- Reset (async, active-high): all outputs 0, state=RUN. Takes effect immediately mid-cycle, including during a squash pulse, which drops at once.
- States:
  - RUN: normal operation.
  - SQUASH: 1 cycle, entered after a taken branch commits.
  - HALTED: terminal until reset.
- Accept mask (combinational, state==RUN only), way i accepted iff:
  - valid[i]=1;
  - all ways j<i accepted;
  - no way j<i has take_branch=1 or halt=1.
  - Invalid-after-valid gaps end acceptance.
- Latency: accepted packets appear on RF_packet_out exactly 1 cycle later. In cycles with no accept, wr_en=0 on all ways.
- Write enable: wr_en[i]=accepted[i] && dest_reg_idx!=0. Register 0 is never written; wr_data is still driven but ignored.
- Same-destination collision within one group: all enabled ports are driven. The regfile's rule that the highest way wins applies. Testbench checks final regfile value = youngest.
- Taken branch at accepted way k:
  - way k commits, including its link-register write;
  - ways >k are dropped;
  - next cycle: squash_flag=1, redirect_pc=NPC[k], state=SQUASH;
  - following cycle: squash_flag=0, state=RUN.
  - In SQUASH all inputs are ignored (ROB is clearing) and no accepts occur.
- Halt at accepted way k:
  - way k commits;
  - younger ways dropped;
  - next cycle halted=1, state=HALTED.
  - In HALTED no accepts, no writes, no squash; halted stays 1 until reset.
- take_branch and halt on the same packet: halt wins; no squash.
- retire_num <= popcount(accepted) each cycle (0 in SQUASH/HALTED). retired_count <= retired_count + popcount(accepted), modulo 2^CNT_W (wraps silently).
- Simultaneous squash and halt cannot occur; the first-hit rule picks the older way.

Decomposition:
- Shared sys_defs.svh additions:
  - RT_REG_PACKET typedef;
  - RETIRE_STATE enum {RT_RUN, RT_SQUASH, RT_HALTED};
  - RT_WAYS constant = 3.
- ROB_RT_PACKET is reused unchanged.
- One natural sub-module: retire_select, the combinational accept-mask/first-stop priority logic. It outputs accepted[NUM_WAYS], stop_way, stop_is_branch and stop_is_halt.

Test Plan:
1. Full group: 3 valid, dests 1/2/3, values 0xA/0xB/0xC, no branch/halt -> next cycle wr_en=111, idx 1/2/3, data A/B/C, retire_num=3, retired_count=3.
2. Gap and r0:
   - valid=1,0,1 -> only way 0 written, retire_num=1.
   - way 0 dest=0 -> wr_en[0]=0 but retire_num still counts 1.
3. Taken branch at way 1, NPC=0x100, dest=1 (link):
   - next cycle: wr_en=11 (way 2 dropped), squash_flag=1, redirect_pc=0x100;
   - following cycle: squash_flag=0;
   - inputs presented during SQUASH produce no writes and no count.
4. Halt at way 0 with valid ways 1-2 behind it -> retire_num=1, halted=1 next cycle and stays 1 for 10+ cycles while valid packets continue to arrive; no writes.
5. Same packet with take_branch=1 and halt=1 -> halted=1, squash_flag never asserts.
6. Reset asserted asynchronously during a squash pulse -> squash_flag, halted and retired_count drop to 0 before the next edge; after release, a 3-wide group retires normally.
